// File: rtl/router_arbiter.sv
// Two-input packet arbiter with round-robin grant, one-deep registered output
// stage and a mid-packet source-stall timeout that force-releases the grant.
//
//   state  | meaning
//   IDLE   | no grant; arbitrate on the next edge
//   GRANT0 | port 0 owns the output until its last beat is accepted
//   GRANT1 | port 1 owns the output until its last beat is accepted
module router_arbiter #(
  parameter int DW        = 28,
  parameter int STALL_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_src,
  input  logic          out_ready,
  output logic          out_abort,
  output logic [7:0]    pkt_cnt0,
  output logic [7:0]    pkt_cnt1
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  // Timeout fires on the cycle the counter would reach STALL_MAX.
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

  state_t          state, state_nxt;
  logic            rr_last, rr_last_nxt;
  logic [7:0]      stall_cnt;
  logic            granted, gnt_port, out_free;
  logic            sel_valid, sel_last, accept, done, timeout;
  logic [DW-1:0]   sel_data;

  assign granted   = (state != IDLE);
  assign gnt_port  = (state == GRANT1);
  assign out_free  = ~out_valid | out_ready;
  // Ready is masked during reset so nothing is taken in the reset cycle.
  assign in0_ready = ~rst & (state == GRANT0) & out_free;
  assign in1_ready = ~rst & (state == GRANT1) & out_free;

  assign sel_valid = gnt_port ? in1_valid : in0_valid;
  assign sel_data  = gnt_port ? in1_data  : in0_data;
  assign sel_last  = gnt_port ? in1_last  : in0_last;
  assign accept    = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign done      = accept & sel_last;
  assign timeout   = granted & ~sel_valid & (stall_cnt == STALL_LAST);

  // Next-state: arbitrate in IDLE, release on last beat or stall timeout.
  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    case (state)
      IDLE: begin
        if (in0_valid && (!in1_valid || rr_last)) state_nxt = GRANT0;
        else if (in1_valid)                       state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (done || timeout) begin
          state_nxt   = IDLE;
          rr_last_nxt = gnt_port;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
    end
  end

  // Stall counter: only source starvation counts, not output backpressure.
  always_ff @(posedge clk) begin
    if (rst || !granted || accept || timeout) stall_cnt <= '0;
    else if (!sel_valid)                      stall_cnt <= stall_cnt + 8'd1;
  end

  // Output stage: load on accept, drop valid after handshake, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
      out_abort <= 1'b0;
    end else begin
      out_abort <= timeout;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_src   <= gnt_port;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Completed-packet counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (done) begin
      if (gnt_port) pkt_cnt1 <= pkt_cnt1 + 8'd1;
      else          pkt_cnt0 <= pkt_cnt0 + 8'd1;
    end
  end

endmodule

// File: doc/router_arbiter.md
ROUTER_ARBITER -- requirements
Module: router_arbiter

Interface
REQ-001 SHALL have parameter DW, default 28, payload width per beat.
REQ-002 SHALL have parameter STALL_MAX, default 15, cycles of mid-packet source starvation tolerated before forced release (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in0_valid  input  1  port-0 beat valid.
REQ-006 SHALL have port in0_data  input  DW  port-0 beat payload.
REQ-007 SHALL have port in0_last  input  1  port-0 final beat of packet.
REQ-008 SHALL have port in0_ready  output  1  port-0 beat accepted when valid&ready.
REQ-009 SHALL have ports in1_valid, in1_data, in1_last, in1_ready, defined identically to port 0.
REQ-010 SHALL have port out_valid  output  1  registered output beat valid.
REQ-011 SHALL have port out_data  output  DW  registered output payload.
REQ-012 SHALL have port out_last  output  1  registered final beat of packet.
REQ-013 SHALL have port out_src  output  1  source port of current output beat.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when out_valid&out_ready.
REQ-015 SHALL have port out_abort  output  1  one-cycle pulse when a packet is force-released by stall timeout.
REQ-016 SHALL have ports pkt_cnt0, pkt_cnt1  output  8  count of packets completed per port, wrapping.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-018 In IDLE, SHALL grant on the next edge: only one valid -> that port; both valid -> port not granted last (rr_last); neither -> stay IDLE.
REQ-019 Grant SHALL be held until the beat with inX_last=1 is accepted; FSM then returns to IDLE and rr_last updates to that port.
REQ-020 in0_ready SHALL equal (state==GRANT0) & (~out_valid | out_ready); in1_ready likewise for GRANT1; both 0 in IDLE.
REQ-021 An accepted input beat SHALL appear on out_* exactly one cycle later (latency 1); out_src SHALL equal the granted port.
REQ-022 out_valid SHALL clear after handshake when no new beat is accepted the same cycle; out_data/out_last/out_src SHALL hold stable while out_valid&~out_ready.
REQ-023 Throughput SHALL be one beat per cycle when the source is valid and out_ready=1 continuously.
REQ-024 Idle arbitration SHALL take one cycle: back-to-back packets from alternating ports have one bubble between them.
REQ-025 In GRANTx, a stall counter SHALL increment each cycle inX_valid=0 and reset to 0 on an accepted beat; out_ready backpressure SHALL NOT increment it.
REQ-026 When stall counter reaches STALL_MAX, SHALL return to IDLE next edge, pulse out_abort for one cycle, set rr_last to the stalled port, not increment its pkt_cnt, and emit no synthetic last beat.
REQ-027 pkt_cntX SHALL increment by 1 on acceptance of a last beat from port X, wrapping 255 -> 0.
REQ-028 Single-beat packets (valid&last on first beat) SHALL be legal and complete in one accepted beat.
REQ-029 A port's data SHALL never be accepted while the other port holds grant.

Reset
REQ-030 On rst=1 at an edge: state=IDLE, rr_last=1 (port 0 wins first tie), out_valid=0, out_last=0, out_src=0, out_data=0, out_abort=0, stall counter=0, pkt_cnt0=pkt_cnt1=0.
REQ-031 Reset mid-packet SHALL drop the in-flight beat and partial packet with no out_abort pulse; inX_ready SHALL be 0 in the reset cycle.

Verification
REQ-032 Both ports valid at reset release, 3-beat packets, out_ready=1 -> port0 beats at out, then 1 bubble, then port1 beats; pkt_cnt0=1, pkt_cnt1=1.
REQ-033 Port1 only, 4-beat packet, out_ready toggling 1,0,1,0 -> all 4 beats delivered in order, out_data stable during every out_ready=0 cycle, no duplication.
REQ-034 Port0 granted, in0_valid drops after beat 2 for 15 cycles (STALL_MAX=15) -> out_abort pulses once, FSM IDLE, pkt_cnt0 unchanged, port1 then granted if valid.
REQ-035 Port0 sends 256 single-beat packets alone -> pkt_cnt0 wraps to 0, one beat per two cycles (arbitration bubble).
REQ-036 rst asserted during beat 2 of a 5-beat port1 packet -> next cycle all outputs at reset values, in1_ready=0 until new grant.
REQ-037 Port1 in0 continuous stream while port0 asserts valid -> strict alternation of packets by out_src, never two consecutive packets from one port when both pending.
